// File: rtl/sr_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one radix-2 step per cycle with start/busy/done handshake.
module sr_mdu #(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int              CNT_W   = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

   stateT             state;
   logic [CNT_W-1:0]  count;
   logic [2:0]        opReg;
   logic [XLEN-1:0]   aMag;
   logic [XLEN-1:0]   bMag;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN:0]     rem;
   logic              resNeg;
   logic              special;
   logic [XLEN-1:0]   specVal;

   // Operand decode, evaluated only when a start is accepted
   logic            aSigned, bSigned, sA, sB, negIn, specIn;
   logic [XLEN-1:0] absA, absB, specValIn;

   always_comb begin
      aSigned   = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      bSigned   = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      sA        = aSigned & srcA[XLEN-1];
      sB        = bSigned & srcB[XLEN-1];
      absA      = sA ? -srcA : srcA;
      absB      = sB ? -srcB : srcB;
      negIn     = (op == 3'd6) ? sA : (sA ^ sB);
      specIn    = 1'b0;
      specValIn = '0;
      if (op[2] && (srcB == '0)) begin
         specIn    = 1'b1;
         specValIn = op[1] ? srcA : '1;
      end else if (op[2] && !op[0] && (srcA == MIN_NEG) && (srcB == '1)) begin
         specIn    = 1'b1;
         specValIn = op[1] ? '0 : srcA;
      end
   end

   logic [XLEN:0]     mulSum;
   logic [2*XLEN-1:0] prodNext, prodFix;
   logic [XLEN+1:0]   trial;
   logic              trialGe;
   logic [XLEN:0]     remNext;
   logic [XLEN-1:0]   quoNext, quoFix, remFix, finalRes;
   logic              lastStep;

   always_comb begin
      mulSum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? aMag : '0)};
      prodNext = {mulSum, prod[XLEN-1:1]};
      // Restoring step: shift next dividend bit in, keep the difference if it fits
      trial    = {rem, quo[XLEN-1]};
      trialGe  = trial >= {2'b00, bMag};
      remNext  = trialGe ? (XLEN+1)'(trial - {2'b00, bMag}) : trial[XLEN:0];
      quoNext  = {quo[XLEN-2:0], trialGe};
      prodFix  = resNeg ? -prodNext : prodNext;
      quoFix   = resNeg ? -quoNext : quoNext;
      remFix   = resNeg ? -remNext[XLEN-1:0] : remNext[XLEN-1:0];
      if (special)
         finalRes = specVal;
      else if (!opReg[2])
         finalRes = (opReg[1:0] == 2'd0) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
      else
         finalRes = opReg[1] ? remFix : quoFix;
      lastStep = (count == CNT_W'(XLEN-1)) || (EARLY_OUT && special);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         count   <= '0;
         opReg   <= '0;
         aMag    <= '0;
         bMag    <= '0;
         prod    <= '0;
         quo     <= '0;
         rem     <= '0;
         resNeg  <= 1'b0;
         special <= 1'b0;
         specVal <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  state   <= CALC;
                  busy    <= 1'b1;
                  count   <= '0;
                  opReg   <= op;
                  aMag    <= absA;
                  bMag    <= absB;
                  prod    <= {{XLEN{1'b0}}, absB};
                  quo     <= absA;
                  rem     <= '0;
                  resNeg  <= negIn;
                  special <= specIn;
                  specVal <= specValIn;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               prod  <= prodNext;
               quo   <= quoNext;
               rem   <= remNext;
               count <= count + 1'b1;
               if (lastStep) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= finalRes;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_mdu.sv
// Directed and random checks of sr_mdu at XLEN=32 (both EARLY_OUT settings)
// and XLEN=8, covering results, latency, handshake and reset abort.
module tb_sr_mdu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        startA, start8;
   logic [2:0]  opA, op8;
   logic [31:0] srcA32, srcB32;
   logic [7:0]  srcA8, srcB8;
   logic        busyA [2];
   logic        doneA [2];
   logic [31:0] resA  [2];
   logic        busy8, done8;
   logic [7:0]  res8;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   // gi=0 -> EARLY_OUT=1, gi=1 -> EARLY_OUT=0
   for (genvar gi = 0; gi < 2; gi++) begin : gEo
      sr_mdu #(.XLEN(32), .EARLY_OUT(gi == 0)) dut (
         .clk(clk), .rst_n(rst_n), .start(startA), .op(opA),
         .srcA(srcA32), .srcB(srcB32),
         .busy(busyA[gi]), .done(doneA[gi]), .result(resA[gi])
      );
   end

   sr_mdu #(.XLEN(8), .EARLY_OUT(1'b1)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8),
      .srcA(srcA8), .srcB(srcB8),
      .busy(busy8), .done(done8), .result(res8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural RISC-V M reference using native 64-bit arithmetic
   function automatic logic [31:0] refOp(input int n, input logic [2:0] o,
                                         input logic [31:0] a, input logic [31:0] b);
      longint          mask, ua, ub, sa, sb, r;
      longint unsigned pu, pv;
      bit              ovf;
      mask = (longint'(1) << n) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = a[n-1] ? ua - (longint'(1) << n) : ua;
      sb   = b[n-1] ? ub - (longint'(1) << n) : ub;
      ovf  = (sa == -(longint'(1) << (n-1))) && (sb == -1);
      case (o)
         3'd0: r = (ua * ub) & mask;
         3'd1: r = ((sa * sb) >>> n) & mask;
         3'd2: r = ((sa * ub) >>> n) & mask;
         3'd3: begin
            pu = ua;
            pv = ub;
            pu = pu * pv;
            r  = longint'(pu >> n) & mask;
         end
         3'd4: r = (ub == 0) ? mask : ovf ? ua : (sa / sb) & mask;
         3'd5: r = (ub == 0) ? mask : (ua / ub);
         3'd6: r = (ub == 0) ? ua : ovf ? 0 : (sa % sb) & mask;
         default: r = (ub == 0) ? ua : (ua % ub);
      endcase
      return r[31:0];
   endfunction

   function automatic bit isSpec(input int n, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
      longint mask;
      mask = (longint'(1) << n) - 1;
      return o[2] && ((b == 0) ||
             (!o[0] && (longint'(a) == (longint'(1) << (n-1))) && (longint'(b) == mask)));
   endfunction

   task automatic runOp(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] e32,
                        input logic [7:0] a8v, input logic [7:0] b8v, input logic [7:0] e8);
      int   first [3] = '{-1, -1, -1};
      int   nDone [3] = '{0, 0, 0};
      logic busy1 [3] = '{1'b0, 1'b0, 1'b0};
      logic dv    [3];
      logic bv    [3];
      bit   ovl = 1'b0;
      @(negedge clk);
      opA = o; op8 = o; srcA32 = a; srcB32 = b; srcA8 = a8v; srcB8 = b8v;
      startA = 1'b1; start8 = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         startA = 1'b0; start8 = 1'b0;
         dv = '{doneA[0], doneA[1], done8};
         bv = '{busyA[0], busyA[1], busy8};
         for (int d = 0; d < 3; d++) begin
            if (k == 1) busy1[d] = bv[d];
            if (dv[d]) begin
               nDone[d]++;
               if (first[d] < 0) first[d] = k;
            end
            if (dv[d] && bv[d]) ovl = 1'b1;
         end
      end
      $display("%-8s op=%0d a=%h b=%h -> %h/%h  a8=%h b8=%h -> %h  lat=%0d/%0d/%0d",
               tag, o, a, b, resA[0], resA[1], a8v, b8v, res8, first[0], first[1], first[2]);
      check({tag, " res32eo1"}, resA[0], e32);
      check({tag, " res32eo0"}, resA[1], e32);
      check({tag, " res8"}, res8, e8);
      check({tag, " lat32eo1"}, first[0], isSpec(32, o, a, b) ? 2 : 33);
      check({tag, " lat32eo0"}, first[1], 33);
      check({tag, " lat8"}, first[2], isSpec(8, o, {24'd0, a8v}, {24'd0, b8v}) ? 2 : 9);
      check({tag, " doneCount"}, nDone[0] * 100 + nDone[1] * 10 + nDone[2], 111);
      check({tag, " busyFirst"}, {busy1[0], busy1[1], busy1[2]}, 3'b111);
      check({tag, " busyDone"}, ovl, 1'b0);
   endtask

   initial begin
      int          k;
      int          nd;
      logic [2:0]  o;
      logic [31:0] a, b;
      logic [7:0]  a8v, b8v;

      rst_n = 1'b0; startA = 1'b0; start8 = 1'b0; opA = '0; op8 = '0;
      srcA32 = '0; srcB32 = '0; srcA8 = '0; srcB8 = '0;
      repeat (2) @(negedge clk);
      check("rst busy", {busyA[0], busyA[1], busy8}, 3'b000);
      check("rst done", {doneA[0], doneA[1], done8}, 3'b000);
      check("rst res32eo1", resA[0], 32'd0);
      check("rst res32eo0", resA[1], 32'd0);
      check("rst res8", res8, 8'd0);
      rst_n = 1'b1;

      runOp("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 8'd7,   8'hFD, 8'hEB);
      runOp("mulh",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 8'h80,  8'h80, 8'h40);
      runOp("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'hFF,  8'hFF, 8'hFE);
      runOp("mulhsu",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 8'hFF,  8'h02, 8'hFF);
      runOp("divu",    3'd5, 32'd100,      32'd7,        32'd14,       8'd200, 8'd9,  8'd22);
      runOp("remu",    3'd7, 32'd100,      32'd7,        32'd2,        8'd200, 8'd9,  8'd2);
      runOp("div",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 8'hF9,  8'h02, 8'hFD);
      runOp("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 8'hF9,  8'h02, 8'hFF);
      runOp("divOvf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'h80,  8'hFF, 8'h80);
      runOp("remOvf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        8'h80,  8'hFF, 8'h00);
      runOp("rem0",    3'd6, 32'd5,        32'd0,        32'd5,        8'd5,   8'd0,  8'd5);
      runOp("divu0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd5,   8'd0,  8'hFF);
      runOp("divNeg0", 3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 8'hFB,  8'h00, 8'hFF);
      runOp("remNeg0", 3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 8'hFB,  8'h00, 8'hFB);

      for (int i = 0; i < 1000; i++) begin
         o   = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         a8v = 8'($urandom);
         b8v = 8'($urandom);
         case ($urandom_range(0, 9))
            0: begin b = '0; b8v = '0; end
            1: begin a = 32'h80000000; b = '1; a8v = 8'h80; b8v = '1; end
            2: begin b = 32'($urandom_range(1, 15)); b8v = 8'($urandom_range(1, 15)); end
            default: ;
         endcase
         runOp("rand", o, a, b, refOp(32, o, a, b), a8v, b8v,
               8'(refOp(8, o, {24'd0, a8v}, {24'd0, b8v})));
      end

      // Back-to-back start in DONE, with an ignored start pulse mid-CALC
      @(negedge clk);
      opA = 3'd5; srcA32 = 32'd1000; srcB32 = 32'd10; startA = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         startA = 1'b0;
         k++;
      end while (!doneA[0] && k < 40);
      check("b2b lat1", k, 33);
      check("b2b res1", resA[0], 32'd100);
      opA = 3'd0; srcA32 = 32'd6; srcB32 = 32'd7; startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      check("b2b busyNext", busyA[0], 1'b1);
      check("b2b doneNext", doneA[0], 1'b0);
      check("b2b resHeld", resA[0], 32'd100);
      k = 1;
      while (!doneA[0] && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 5) begin
            startA = 1'b1; opA = 3'd5; srcA32 = 32'd9; srcB32 = 32'd3;
         end else begin
            startA = 1'b0;
         end
      end
      check("b2b lat2", k, 33);
      check("b2b res2eo1", resA[0], 32'd42);
      check("b2b res2eo0", resA[1], 32'd42);
      $display("b2b      divu 1000/10 then mul 6*7 -> %h", resA[0]);

      // Reset during CALC cycle 10 aborts without a done pulse
      @(negedge clk);
      opA = 3'd0; srcA32 = 32'h12345678; srcB32 = 32'd3; startA = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         startA = 1'b0;
      end
      check("abort busyBefore", busyA[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort busy", {busyA[0], busyA[1], busy8}, 3'b000);
      check("abort done", {doneA[0], doneA[1], done8}, 3'b000);
      check("abort res32eo1", resA[0], 32'd0);
      check("abort res32eo0", resA[1], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         nd += int'(doneA[0]) + int'(doneA[1]) + int'(busyA[0]) + int'(busyA[1]);
      end
      check("abort quiet", nd, 0);
      $display("abort    reset in CALC cycle 10, activity after=%0d", nd);

      runOp("postRst", 3'd0, 32'h12345678, 32'd3, 32'h369D0368, 8'h12, 8'd3, 8'h36);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
